// File: rtl/multiplier_controller.sv
// Sequencer for the N-bit shift-and-add multiplier datapath with a one-deep result buffer.
// Optional feature: define MULT_ABORT_EN to add the abort input that cancels an in-flight operation.
module multiplier_controller #(
    parameter int N = 4
) (
    input  logic             clock,
    input  logic             reset,
`ifdef MULT_ABORT_EN
    input  logic             abort,
`endif
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_multiplicand,
    input  logic [N-1:0]     req_multiplier,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*N-1:0]   res_product,
    output logic             busy,
    output logic             dp_do_init,
    output logic             dp_do_shift,
    output logic [N-1:0]     dp_multiplicand,
    output logic [N-1:0]     dp_multiplier,
    input  logic [2*N-1:0]   dp_product
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] shift_count;
    logic          slot_free;
    logic          abort_req;

    assign req_ready = (state == IDLE);
    assign slot_free = !res_valid || res_ready;

`ifdef MULT_ABORT_EN
    assign abort_req = abort && ((state == INIT) || (state == SHIFT));
`else
    assign abort_req = 1'b0;
`endif

    // Strobes are registered alongside the state so each one is high exactly while in its state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            shift_count     <= '0;
            dp_multiplicand <= '0;
            dp_multiplier   <= '0;
            res_product     <= '0;
            res_valid       <= 1'b0;
            dp_do_init      <= 1'b0;
            dp_do_shift     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (abort_req) begin
                state       <= IDLE;
                shift_count <= '0;
                dp_do_init  <= 1'b0;
                dp_do_shift <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            dp_multiplicand <= req_multiplicand;
                            dp_multiplier   <= req_multiplier;
                            dp_do_init      <= 1'b1;
                            busy            <= 1'b1;
                            state           <= INIT;
                        end
                    end
                    INIT: begin
                        dp_do_init  <= 1'b0;
                        dp_do_shift <= 1'b1;
                        shift_count <= COUNT_LAST;
                        state       <= SHIFT;
                    end
                    SHIFT: begin
                        if (shift_count == '0) begin
                            dp_do_shift <= 1'b0;
                            state       <= DONE;
                        end else begin
                            shift_count <= shift_count - 1'b1;
                        end
                    end
                    DONE: begin
                        // A consumer taking the old result this cycle frees the slot for the new one.
                        if (slot_free) begin
                            res_product <= dp_product;
                            res_valid   <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multiplier_controller.sv
// Scoreboard bench for multiplier_controller: N=4 and N=8 instances, each driving a behavioural datapath.
// Abort scenario is included when MULT_ABORT_EN is defined.
module tb_multiplier_controller;

    localparam int N = 4;
    localparam int M = 8;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    logic           req_valid, req_ready, res_valid, res_ready, busy;
    logic           dp_do_init, dp_do_shift;
    logic [N-1:0]   req_multiplicand, req_multiplier, dp_multiplicand, dp_multiplier;
    logic [2*N-1:0] res_product, dp_product;
    logic [N-1:0]   dm_a, dm_q;
    logic [N:0]     dm_sum;
`ifdef MULT_ABORT_EN
    logic           abort;
`endif

    logic           req_valid8, req_ready8, res_valid8, res_ready8, busy8;
    logic           dp_do_init8, dp_do_shift8;
    logic [M-1:0]   req_multiplicand8, req_multiplier8, dp_multiplicand8, dp_multiplier8;
    logic [2*M-1:0] res_product8, dp_product8;
    logic [M-1:0]   dm_a8, dm_q8;
    logic [M:0]     dm_sum8;

    multiplier_controller #(.N(N)) dut (
        .clock(clock), .reset(reset),
`ifdef MULT_ABORT_EN
        .abort(abort),
`endif
        .req_valid(req_valid), .req_ready(req_ready),
        .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
        .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
        .busy(busy), .dp_do_init(dp_do_init), .dp_do_shift(dp_do_shift),
        .dp_multiplicand(dp_multiplicand), .dp_multiplier(dp_multiplier),
        .dp_product(dp_product)
    );

    multiplier_controller #(.N(M)) dut8 (
        .clock(clock), .reset(reset),
`ifdef MULT_ABORT_EN
        .abort(1'b0),
`endif
        .req_valid(req_valid8), .req_ready(req_ready8),
        .req_multiplicand(req_multiplicand8), .req_multiplier(req_multiplier8),
        .res_valid(res_valid8), .res_ready(res_ready8), .res_product(res_product8),
        .busy(busy8), .dp_do_init(dp_do_init8), .dp_do_shift(dp_do_shift8),
        .dp_multiplicand(dp_multiplicand8), .dp_multiplier(dp_multiplier8),
        .dp_product(dp_product8)
    );

    // Behavioural shift-and-add datapaths: {a,q} shifted right after adding the multiplicand when q[0]=1.
    assign dm_sum     = {1'b0, dm_a} + (dm_q[0] ? {1'b0, dp_multiplicand} : {(N+1){1'b0}});
    assign dp_product = {dm_a, dm_q};

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dm_a <= '0;
            dm_q <= '0;
        end else if (dp_do_init) begin
            dm_a <= '0;
            dm_q <= dp_multiplier;
        end else if (dp_do_shift) begin
            dm_a <= dm_sum[N:1];
            dm_q <= {dm_sum[0], dm_q[N-1:1]};
        end
    end

    assign dm_sum8     = {1'b0, dm_a8} + (dm_q8[0] ? {1'b0, dp_multiplicand8} : {(M+1){1'b0}});
    assign dp_product8 = {dm_a8, dm_q8};

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dm_a8 <= '0;
            dm_q8 <= '0;
        end else if (dp_do_init8) begin
            dm_a8 <= '0;
            dm_q8 <= dp_multiplier8;
        end else if (dp_do_shift8) begin
            dm_a8 <= dm_sum8[M:1];
            dm_q8 <= {dm_sum8[0], dm_q8[M-1:1]};
        end
    end

    int errors = 0;
    int checks = 0;

    logic [2*N-1:0] sb4[$];
    logic [2*M-1:0] sb8[$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Monitors: pop the scoreboard on every result handshake, and check hold while stalled.
    logic           held;
    logic [2*N-1:0] held_val;
    bit             both_seen = 1'b0;
    int             init_cnt = 0;
    int             shift_cnt = 0;

    always @(negedge clock) begin
        if (!reset && res_valid && res_ready) begin
            if (sb4.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result4: got 0x%0h, expected no result", res_product);
            end else begin
                checkOutput("product4", 64'(res_product), 64'(sb4.pop_front()));
            end
        end
        if (!reset && res_valid8 && res_ready8) begin
            if (sb8.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result8: got 0x%0h, expected no result", res_product8);
            end else begin
                checkOutput("product8", 64'(res_product8), 64'(sb8.pop_front()));
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && held) begin
            checkOutput("held_valid", 64'(res_valid), 64'(1));
            checkOutput("held_product", 64'(res_product), 64'(held_val));
        end
        held     = !reset && res_valid && !res_ready;
        held_val = res_product;
        if (dp_do_init && dp_do_shift) both_seen = 1'b1;
        if (dp_do_init) init_cnt++;
        if (dp_do_shift) shift_cnt++;
    end

    // Wait for IDLE, present one request for one edge, and record the expected product.
    task automatic applyStimulus(input logic [N-1:0] mcand, input logic [N-1:0] mplier,
                                 input logic [2*N-1:0] expected, input bit push);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            got = req_ready;
        end
        checkOutput("req_ready_wait", 64'(got), 64'(1));
        req_multiplicand = mcand;
        req_multiplier   = mplier;
        req_valid        = 1'b1;
        if (push) sb4.push_back(expected);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        init_cnt  = 0;
        shift_cnt = 0;
    endtask

    // Count cycles after acceptance until res_valid appears; check req_ready/busy while busy.
    task automatic waitResult(input int exp_lat, input bit noise);
        int lat = -1;
        bit busy_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (res_valid) begin
                lat = k;
                break;
            end
            if (req_ready || !busy) busy_ok = 1'b0;
            if (noise && k == 2) begin
                req_multiplicand = 4'hA;
                req_multiplier   = 4'h6;
                req_valid        = 1'b1;
            end
            if (noise && k == 3) req_valid = 1'b0;
        end
        checkOutput("latency", 64'(lat), 64'(exp_lat));
        checkOutput("busy_period", 64'(busy_ok), 64'(1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat8;
        reset             = 1'b1;
        req_valid         = 1'b0;
        res_ready         = 1'b1;
        req_multiplicand  = '0;
        req_multiplier    = '0;
        req_valid8        = 1'b0;
        res_ready8        = 1'b1;
        req_multiplicand8 = '0;
        req_multiplier8   = '0;
`ifdef MULT_ABORT_EN
        abort             = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_req_ready", 64'(req_ready), 64'(1));
        checkOutput("rst_res_valid", 64'(res_valid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_strobes", 64'({dp_do_init, dp_do_shift}), 64'(0));
        checkOutput("rst_product", 64'(res_product), 64'(0));

        $display("[TB] 3*5 with latency and strobe counts");
        applyStimulus(4'd3, 4'd5, 8'h0F, 1'b1);
        waitResult(7, 1'b0);
        checkOutput("init_pulses", 64'(init_cnt), 64'(1));
        checkOutput("shift_pulses", 64'(shift_cnt), 64'(4));
        @(negedge clock);
        checkOutput("valid_one_cycle", 64'(res_valid), 64'(0));

        $display("[TB] 15*15, 0*9, 9*0");
        applyStimulus(4'd15, 4'd15, 8'hE1, 1'b1);
        waitResult(7, 1'b1);
        applyStimulus(4'd0, 4'd9, 8'h00, 1'b1);
        waitResult(7, 1'b0);
        applyStimulus(4'd9, 4'd0, 8'h00, 1'b1);
        waitResult(7, 1'b0);

        $display("[TB] stalled consumer: 2*3 then 7*7");
        @(posedge clock);
        #1 res_ready = 1'b0;
        applyStimulus(4'd2, 4'd3, 8'h06, 1'b1);
        waitResult(7, 1'b0);
        applyStimulus(4'd7, 4'd7, 8'h31, 1'b1);
        repeat (10) @(negedge clock);
        checkOutput("stall_busy", 64'(busy), 64'(1));
        checkOutput("stall_req_ready", 64'(req_ready), 64'(0));
        checkOutput("stall_strobes", 64'({dp_do_init, dp_do_shift}), 64'(0));
        checkOutput("stall_product", 64'(res_product), 64'(8'h06));
        @(posedge clock);
        #1 res_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("after_stall_valid", 64'(res_valid), 64'(1));
        checkOutput("after_stall_product", 64'(res_product), 64'(8'h31));
        checkOutput("after_stall_idle", 64'(busy), 64'(0));

        $display("[TB] reset during second shift cycle");
        applyStimulus(4'd5, 4'd3, 8'h0F, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("pre_reset_shift", 64'(dp_do_shift), 64'(1));
        reset = 1'b1;
        @(negedge clock);
        checkOutput("mid_rst_req_ready", 64'(req_ready), 64'(1));
        checkOutput("mid_rst_res_valid", 64'(res_valid), 64'(0));
        checkOutput("mid_rst_busy", 64'(busy), 64'(0));
        checkOutput("mid_rst_strobes", 64'({dp_do_init, dp_do_shift}), 64'(0));
        checkOutput("mid_rst_operands", 64'({dp_multiplicand, dp_multiplier}), 64'(0));
        @(posedge clock);
        #1 reset = 1'b0;
        applyStimulus(4'd6, 4'd7, 8'h2A, 1'b1);
        waitResult(7, 1'b0);

`ifdef MULT_ABORT_EN
        $display("[TB] abort during shift");
        applyStimulus(4'd5, 4'd5, 8'h19, 1'b0);
        repeat (3) @(negedge clock);
        abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        @(negedge clock);
        checkOutput("abort_idle", 64'({busy, req_ready}), 64'(2'b01));
        checkOutput("abort_res_valid", 64'(res_valid), 64'(0));
        checkOutput("abort_strobes", 64'({dp_do_init, dp_do_shift}), 64'(0));
        applyStimulus(4'd4, 4'd4, 8'h10, 1'b1);
        waitResult(7, 1'b0);
`endif

        $display("[TB] N=8 255*255");
        @(negedge clock);
        checkOutput("ready8", 64'(req_ready8), 64'(1));
        req_multiplicand8 = 8'd255;
        req_multiplier8   = 8'd255;
        req_valid8        = 1'b1;
        sb8.push_back(16'hFE01);
        @(posedge clock);
        #1 req_valid8 = 1'b0;
        lat8 = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (res_valid8) begin
                lat8 = k;
                break;
            end
        end
        checkOutput("latency8", 64'(lat8), 64'(11));
        checkOutput("product8_direct", 64'(res_product8), 64'(16'hFE01));

        repeat (4) @(negedge clock);
        checkOutput("sb4_drained", 64'(sb4.size()), 64'(0));
        checkOutput("sb8_drained", 64'(sb8.size()), 64'(0));
        checkOutput("strobes_exclusive", 64'(both_seen), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
